matrix_packer: RTL and testbench
================================

Name: matrix_packer

Overview:
- Write-side counterpart of the matrix element selector in the multiplier datapath.
- Accepts a stream of ELEM_W-bit elements over a valid/ready handshake and packs them into an N_ELEM-element matrix word. Slot k occupies bits [ELEM_W*k+ELEM_W-1 : ELEM_W*k], which is the same layout the selector reads.
- Double-buffered: a staging register fills while the previously completed matrix is held on the output until it is consumed.
- Sits between the multiply/accumulate stage and result storage.

Parameters:
ELEM_W, 4, width of one matrix element in bits
N_ELEM, 4, elements per matrix (2x2); MAT_W = ELEM_W*N_ELEM

Ports:
clk  input  1  clock; all state updates on posedge clk
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous flush, active high
elem_in  input  ELEM_W  element data
elem_valid  input  1  elem_in valid
elem_ready  output  1  packer accepts elem_in this cycle
matrix_out  output  MAT_W  packed matrix, slot 0 in LSBs
matrix_valid  output  1  matrix_out holds a complete matrix
matrix_ready  input  1  consumer takes matrix_out this cycle
fill_count  output  clog2(N_ELEM)+1  elements currently in staging
overrun  output  1  sticky: elem_valid seen while elem_ready=0 (IDLE excluded)

Behaviour:
- Reset (rst_n=0 at posedge) is synchronous, active-low; fixed decision.
- Reset values: all outputs and state are registered and go to zero at that edge.
  - elem_ready=0, matrix_valid=0, matrix_out=0, fill_count=0, overrun=0, staging=0, state=IDLE.
- States:
  - IDLE: one cycle after reset deasserts, then FILL, with elem_ready=1 from the next cycle.
  - FILL: elem_ready=1. Each accept (elem_valid&&elem_ready) writes elem_in into staging slot fill_count, then fill_count++.
  - HOLD: staging complete, output slot occupied; elem_ready=0.
- Completion on accept of slot N_ELEM-1 at cycle t:
  - Output empty at t, or matrix_valid&&matrix_ready at t: at t+1 matrix_out=staging incl. the new element, matrix_valid=1, fill_count=0, stay FILL, elem_ready=1.
  - Otherwise: at t+1 state=HOLD, fill_count=N_ELEM, elem_ready=0.
- HOLD exit: on the cycle u where matrix_valid&&matrix_ready, at u+1:
  - matrix_out=staging, matrix_valid stays 1, fill_count=0, FILL, elem_ready=1.
- Output consume with no pending staging: matrix_valid=0 next cycle. matrix_out keeps its last value (don't-care while invalid).
- matrix_out is stable while matrix_valid=1 and unconsumed.
- Throughput: one element per cycle sustained when the consumer keeps matrix_ready=1; no bubble between matrices.
- Elements are never lost: inputs while elem_ready=0 are ignored, and set overrun when state is FILL or HOLD.
- clear:
  - Next cycle: staging=0, fill_count=0, matrix_valid=0, matrix_out=0, overrun=0, state=FILL, elem_ready=1.
  - clear beats a simultaneous element accept and a simultaneous matrix handshake (that matrix counts as not delivered).
- Reset beats clear. Reset mid-fill discards the partial matrix.
- Widths: fill_count saturates at N_ELEM (HOLD only). No arithmetic on element data; elements are stored bit-exact.

Decomposition:
- Shared package matrix_pkg holds:
  - ELEM_W, N_ELEM, MAT_W constants.
  - clog2-derived COUNT_W.
  - State enum IDLE/FILL/HOLD.
  - Slot-to-bit-offset function, also used by the selector side.
- No sub-module; the staging write decoder is a per-slot enable inside this block.

Test Plan:
- Reset, then feed 4'h1,4'h2,4'h3,4'h4 on consecutive cycles with matrix_ready=1:
  - elem_ready=1 from the 2nd cycle after reset release.
  - One cycle after the last accept: matrix_out=16'h4321, matrix_valid=1.
- matrix_ready=0, stream two matrices 1,2,3,4 then 5,6,7,8:
  - First matrix 16'h4321 held.
  - elem_ready drops one cycle after element 8 is accepted; fill_count=4.
  - Pulse matrix_ready: next cycle matrix_out=16'h8765, matrix_valid=1, elem_ready=1.
- Last element accepted in the same cycle as matrix_valid&&matrix_ready:
  - Next cycle the new matrix is valid; matrix_valid never drops; no HOLD.
- In HOLD, drive elem_valid=1, elem_in=4'hF:
  - overrun=1, staging unchanged.
  - After consume, output equals the earlier staging, not 4'hF.
- After 2 elements, assert clear together with elem_valid:
  - Next cycle fill_count=0, matrix_valid=0, overrun=0.
  - A fresh 4-element load 9,A,B,C gives 16'hCBA9.
- Assert rst_n=0 mid-fill and while HOLD:
  - All outputs 0 at that edge, IDLE, then FILL after deassertion; the partial matrix never appears on the output.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix packer and selector: element geometry,
// fill-counter width, packer state encoding and the slot-to-bit mapping.
package matrix_pkg;

  localparam int ELEM_W  = 4;
  localparam int N_ELEM  = 4;
  localparam int MAT_W   = ELEM_W * N_ELEM;
  localparam int COUNT_W = $clog2(N_ELEM) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Slot k lives at bits [ELEM_W*k +: ELEM_W]; the selector reads the same layout.
  function automatic int slot_lsb(input int slot);
    return slot * ELEM_W;
  endfunction

endpackage

// File: rtl/matrix_packer.sv
// Double-buffered packer: collects N_ELEM elements into a staging word and
// presents each completed matrix on a valid/ready output port.
module matrix_packer
  import matrix_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [ELEM_W-1:0]  elem_in,
  input  logic               elem_valid,
  output logic               elem_ready,
  output logic [MAT_W-1:0]   matrix_out,
  output logic               matrix_valid,
  input  logic               matrix_ready,
  output logic [COUNT_W-1:0] fill_count,
  output logic               overrun
);

  state_t             state;
  state_t             state_next;
  logic [MAT_W-1:0]   staging;
  logic [MAT_W-1:0]   staging_next;
  logic [N_ELEM-1:0]  slot_en;
  logic               accept;
  logic               consume;
  logic               last_accept;
  logic               out_free;

  assign accept      = elem_valid && elem_ready;
  assign consume     = matrix_valid && matrix_ready;
  assign last_accept = accept && (fill_count == COUNT_W'(N_ELEM - 1));
  assign out_free    = !matrix_valid || consume;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FILL;
    end else begin
      case (state)
        IDLE:    state_next = FILL;
        FILL:    if (last_accept && !out_free) state_next = HOLD;
        HOLD:    if (consume) state_next = FILL;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    elem_ready = (state == FILL);
  end

  // Per-slot write enable: only the slot addressed by fill_count takes elem_in.
  always_comb begin
    slot_en      = '0;
    staging_next = staging;
    for (int k = 0; k < N_ELEM; k++) begin
      slot_en[k] = accept && (fill_count == COUNT_W'(k));
      if (slot_en[k]) staging_next[slot_lsb(k) +: ELEM_W] = elem_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      staging      <= '0;
      fill_count   <= '0;
      matrix_out   <= '0;
      matrix_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (elem_valid && !elem_ready && state != IDLE) overrun <= 1'b1;
      staging <= staging_next;

      if (last_accept) begin
        if (out_free) begin
          matrix_out   <= staging_next;
          matrix_valid <= 1'b1;
          fill_count   <= '0;
        end else begin
          fill_count   <= COUNT_W'(N_ELEM);
        end
      end else if (accept) begin
        fill_count <= fill_count + COUNT_W'(1);
      end

      // A consume in HOLD swaps the parked staging word straight onto the output.
      if (state == HOLD && consume) begin
        matrix_out <= staging;
        fill_count <= '0;
      end else if (consume && !last_accept) begin
        matrix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_packer.sv
// Directed bench for matrix_packer: expected matrices go into a scoreboard
// queue at stimulus time and a monitor checks every delivered matrix.
module tb_matrix_packer;
  import matrix_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic [ELEM_W-1:0]  elem_in;
  logic               elem_valid;
  logic               elem_ready;
  logic [MAT_W-1:0]   matrix_out;
  logic               matrix_valid;
  logic               matrix_ready;
  logic [COUNT_W-1:0] fill_count;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [MAT_W-1:0] expected_q[$];

  matrix_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .elem_in      (elem_in),
    .elem_valid   (elem_valid),
    .elem_ready   (elem_ready),
    .matrix_out   (matrix_out),
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready),
    .fill_count   (fill_count),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [ELEM_W-1:0] value);
    elem_in    = value;
    elem_valid = 1'b1;
    tick();
    elem_valid = 1'b0;
  endtask

  task automatic feed_matrix(input logic [MAT_W-1:0] mat);
    logic [MAT_W-1:0] m;
    m = mat;
    expected_q.push_back(m);
    for (int k = 0; k < N_ELEM; k++) apply_stimulus(m[k*ELEM_W +: ELEM_W]);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " elem_ready"},   32'(elem_ready),   32'd0);
    check_output({tag, " matrix_valid"}, 32'(matrix_valid), 32'd0);
    check_output({tag, " matrix_out"},   32'(matrix_out),   32'd0);
    check_output({tag, " fill_count"},   32'(fill_count),   32'd0);
    check_output({tag, " overrun"},      32'(overrun),      32'd0);
  endtask

  // Monitor: every accepted output handshake must match the oldest expected matrix.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && !clear && matrix_valid && matrix_ready) begin
        if (expected_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_matrix: got %0h, expected none", matrix_out);
        end else begin
          check_output("delivered_matrix", 32'(matrix_out), 32'(expected_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; elem_in = '0; elem_valid = 1'b0; matrix_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");

    // Release: one IDLE cycle, then FILL.
    rst_n = 1'b1;
    check_output("idle elem_ready", 32'(elem_ready), 32'd0);
    tick();
    check_output("fill elem_ready", 32'(elem_ready), 32'd1);

    // Streaming with consumer always ready.
    matrix_ready = 1'b1;
    feed_matrix(16'h4321);
    check_output("t1 matrix_valid", 32'(matrix_valid), 32'd1);
    check_output("t1 matrix_out",   32'(matrix_out),   32'h4321);
    check_output("t1 fill_count",   32'(fill_count),   32'd0);
    tick();
    check_output("t1 drained valid", 32'(matrix_valid), 32'd0);

    // Back-pressure: second matrix parks in HOLD.
    matrix_ready = 1'b0;
    feed_matrix(16'h4321);
    feed_matrix(16'h8765);
    check_output("t2 elem_ready",  32'(elem_ready), 32'd0);
    check_output("t2 fill_count",  32'(fill_count), 32'd4);
    check_output("t2 held out",    32'(matrix_out), 32'h4321);
    matrix_ready = 1'b1;
    tick();
    matrix_ready = 1'b0;
    check_output("t2 swap out",    32'(matrix_out),   32'h8765);
    check_output("t2 swap valid",  32'(matrix_valid), 32'd1);
    check_output("t2 swap ready",  32'(elem_ready),   32'd1);
    check_output("t2 swap count",  32'(fill_count),   32'd0);
    matrix_ready = 1'b1;
    tick();
    matrix_ready = 1'b0;
    check_output("t2 empty valid", 32'(matrix_valid), 32'd0);

    // Last element accepted in the same cycle the held matrix is consumed.
    feed_matrix(16'h4321);
    expected_q.push_back(16'hDCBA);
    apply_stimulus(4'hA); apply_stimulus(4'hB); apply_stimulus(4'hC);
    matrix_ready = 1'b1;
    apply_stimulus(4'hD);
    matrix_ready = 1'b0;
    check_output("t3 valid",      32'(matrix_valid), 32'd1);
    check_output("t3 out",        32'(matrix_out),   32'hDCBA);
    check_output("t3 elem_ready", 32'(elem_ready),   32'd1);
    check_output("t3 fill_count", 32'(fill_count),   32'd0);
    matrix_ready = 1'b1;
    tick();
    matrix_ready = 1'b0;

    // Input while in HOLD is dropped and flagged.
    feed_matrix(16'h4321);
    feed_matrix(16'h8765);
    check_output("t4 no overrun yet", 32'(overrun), 32'd0);
    apply_stimulus(4'hF);
    check_output("t4 overrun",    32'(overrun),    32'd1);
    check_output("t4 fill_count", 32'(fill_count), 32'd4);
    check_output("t4 elem_ready", 32'(elem_ready), 32'd0);
    matrix_ready = 1'b1;
    tick();
    check_output("t4 swap out", 32'(matrix_out), 32'h8765);
    tick();
    matrix_ready = 1'b0;
    check_output("t4 overrun sticky", 32'(overrun), 32'd1);

    // Clear beats a simultaneous accept and wipes overrun.
    apply_stimulus(4'h1); apply_stimulus(4'h2);
    clear = 1'b1;
    apply_stimulus(4'h3);
    clear = 1'b0;
    check_output("t5 fill_count",   32'(fill_count),   32'd0);
    check_output("t5 matrix_valid", 32'(matrix_valid), 32'd0);
    check_output("t5 overrun",      32'(overrun),      32'd0);
    check_output("t5 elem_ready",   32'(elem_ready),   32'd1);
    matrix_ready = 1'b1;
    feed_matrix(16'hCBA9);
    check_output("t5 out", 32'(matrix_out), 32'hCBA9);
    tick();
    matrix_ready = 1'b0;

    // Reset in the middle of a fill.
    apply_stimulus(4'h1); apply_stimulus(4'h2);
    check_output("t6 partial count", 32'(fill_count), 32'd2);
    rst_n = 1'b0;
    tick();
    check_all_zero("t6 reset");
    rst_n = 1'b1;
    tick();
    check_output("t6 elem_ready", 32'(elem_ready), 32'd1);
    matrix_ready = 1'b1;
    feed_matrix(16'h8765);
    tick();
    matrix_ready = 1'b0;

    // Reset while in HOLD: nothing pending may ever appear.
    feed_matrix(16'h4321);
    feed_matrix(16'h8765);
    check_output("t7 hold ready", 32'(elem_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    expected_q.delete();
    check_all_zero("t7 reset");
    rst_n = 1'b1;
    check_output("t7 idle ready", 32'(elem_ready), 32'd0);
    tick();
    check_output("t7 fill ready", 32'(elem_ready), 32'd1);
    matrix_ready = 1'b1;
    tick(); tick();
    check_output("t7 no stale valid", 32'(matrix_valid), 32'd0);
    matrix_ready = 1'b0;

    check_output("scoreboard empty", 32'(expected_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
